// File: rtl/debouncer.sv
// Push-button debouncer: 2-flop synchroniser plus a 4-state FSM that
// accepts a new level after STABLE consecutive agreeing strobed samples.
// Ports: clk, rst (async active-low), ena, tick (sample strobe), button (raw),
//        debounced (accepted level), rise/fall (one-cycle edge pulses).
module debouncer #(
  parameter int N      = 4,
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic tick,
  input  logic button,
  output logic debounced,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    S_LOW,
    S_MAYBE_HIGH,
    S_HIGH,
    S_MAYBE_LOW
  } state_t;

  localparam logic [N-1:0] STABLE_C = N'(STABLE);
  localparam logic [N-1:0] ONE_C    = N'(1);

  logic         sync1_q;
  logic         sync_q;
  state_t       state_q;
  logic [N-1:0] count_q;
  logic         debounced_q;
  logic         rise_q;
  logic         fall_q;

  logic         sample;
  logic [N-1:0] count_d;
  logic         done;

  assign sample  = ena & tick;
  assign count_d = count_q + ONE_C;
  // This sample would be the STABLE-th consecutive agreeing one.
  assign done    = (count_d == STABLE_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= button;
      sync_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOW;
      count_q     <= '0;
      debounced_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      // Edge pulses last one cycle whether or not a sample occurs.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sample) begin
        unique case (state_q)
          S_LOW: begin
            if (sync_q) begin
              state_q <= S_MAYBE_HIGH;
              count_q <= ONE_C;
            end
          end
          S_MAYBE_HIGH: begin
            if (!sync_q) begin
              state_q <= S_LOW;
              count_q <= '0;
            end else if (done) begin
              state_q     <= S_HIGH;
              count_q     <= '0;
              debounced_q <= 1'b1;
              rise_q      <= 1'b1;
            end else begin
              count_q <= count_d;
            end
          end
          S_HIGH: begin
            if (!sync_q) begin
              state_q <= S_MAYBE_LOW;
              count_q <= ONE_C;
            end
          end
          S_MAYBE_LOW: begin
            if (sync_q) begin
              state_q <= S_HIGH;
              count_q <= '0;
            end else if (done) begin
              state_q     <= S_LOW;
              count_q     <= '0;
              debounced_q <= 1'b0;
              fall_q      <= 1'b1;
            end else begin
              count_q <= count_d;
            end
          end
          default: begin
            state_q <= S_LOW;
            count_q <= '0;
          end
        endcase
      end
    end
  end

  assign debounced = debounced_q;
  assign rise      = rise_q;
  assign fall      = fall_q;

endmodule
